// File: rtl/motor_pkg.sv
// motor_pkg
// Shared definitions for the motor command sequencer:
//   - DIR_* : motor driver direction encodings (11 fwd, 00 bwd, 01 halt)
//   - CMD_* : ASCII command bytes understood by the sequencer
//   - chan_state_t : per-channel direction FSM states
//   - state_to_dir : maps a channel state onto its driver encoding
package motor_pkg;

  localparam logic [1:0] DIR_FWD  = 2'b11;
  localparam logic [1:0] DIR_BWD  = 2'b00;
  localparam logic [1:0] DIR_HALT = 2'b01;

  localparam logic [7:0] CMD_FWD   = 8'h46;  // 'F'
  localparam logic [7:0] CMD_BWD   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_LEFT  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RIGHT = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

  typedef enum logic [1:0] {
    ST_HALT,
    ST_FWD,
    ST_BWD,
    ST_DEAD
  } chan_state_t;

  // Only FWD and BWD drive the motor; HALT and DEAD both brake with 01,
  // so the illegal 10 pattern can never be produced.
  function automatic logic [1:0] state_to_dir(input chan_state_t s);
    case (s)
      ST_FWD:  return DIR_FWD;
      ST_BWD:  return DIR_BWD;
      default: return DIR_HALT;
    endcase
  endfunction

endpackage

// File: rtl/motor_dir_seq.sv
// motor_dir_seq
// Direction sequencer for one motor channel. Follows the requested target
// direction, but a reversal (FWD<->BWD) is routed through a DEAD state that
// brakes the motor for exactly DEAD_US clock cycles before the new direction
// is applied.
// Ports:
//   clk_1MHz : 1 MHz system clock
//   rst_n    : asynchronous active-low reset
//   target   : requested direction (DIR_FWD / DIR_BWD / DIR_HALT)
//   dir      : registered driver direction output
module motor_dir_seq
  import motor_pkg::*;
#(
  parameter int DEAD_US = 20000
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [1:0] target,
  output logic [1:0] dir
);

  localparam int DCW = (DEAD_US > 0) ? $clog2(DEAD_US + 1) : 1;
  // Value of the counter during the final dead cycle; the counter starts at
  // zero on entry, so DEAD lasts DEAD_US cycles.
  localparam logic [DCW-1:0] DEAD_LAST = (DEAD_US > 1) ? DCW'(DEAD_US - 1) : '0;

  chan_state_t    state, state_next;
  logic [DCW-1:0] dead_cnt, dead_cnt_next;
  logic           tgt_fwd, tgt_bwd;

  assign tgt_fwd = (target == DIR_FWD);
  assign tgt_bwd = (target == DIR_BWD);

  // Next-state logic. The dead counter is held at zero outside DEAD so every
  // reversal starts a fresh dead period. A flip back to the original
  // direction during DEAD keeps counting; only a halt target cuts it short.
  always_comb begin
    state_next    = state;
    dead_cnt_next = '0;
    case (state)
      ST_HALT: begin
        if (tgt_fwd)      state_next = ST_FWD;
        else if (tgt_bwd) state_next = ST_BWD;
      end
      ST_FWD: begin
        if (tgt_bwd)       state_next = ST_DEAD;
        else if (!tgt_fwd) state_next = ST_HALT;
      end
      ST_BWD: begin
        if (tgt_fwd)       state_next = ST_DEAD;
        else if (!tgt_bwd) state_next = ST_HALT;
      end
      ST_DEAD: begin
        if (!tgt_fwd && !tgt_bwd) begin
          state_next = ST_HALT;
        end else if (dead_cnt == DEAD_LAST) begin
          state_next = tgt_fwd ? ST_FWD : ST_BWD;
        end else begin
          dead_cnt_next = dead_cnt + 1'b1;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // The output register is loaded from the next state so it changes on the
  // same edge as the state register and never glitches while the state holds.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HALT;
      dead_cnt <= '0;
      dir      <= DIR_HALT;
    end else begin
      state    <= state_next;
      dead_cnt <= dead_cnt_next;
      dir      <= state_to_dir(state_next);
    end
  end

endmodule

// File: rtl/motor_cmd_seq.sv
// motor_cmd_seq
// Two-wheel motor command sequencer. Accepts ASCII command bytes, decodes
// them into left/right target directions and hands each target to its own
// motor_dir_seq channel. A watchdog forces both targets to halt when no valid
// command has arrived for TIMEOUT_MS milliseconds.
// Ports:
//   clk_1MHz     : 1 MHz system clock
//   rst_n        : asynchronous active-low reset
//   cmd_valid    : command byte present
//   cmd_data     : command byte
//   cmd_ready    : registered, high in every cycle out of reset
//   dir_left     : left driver direction (11 fwd, 00 bwd, 01 halt)
//   dir_right    : right driver direction, same encoding
//   timeout_flag : watchdog expired, motors forced to halt
module motor_cmd_seq
  import motor_pkg::*;
#(
  parameter int DEAD_US    = 20000,
  parameter int TIMEOUT_MS = 500
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [1:0] dir_left,
  output logic [1:0] dir_right,
  output logic       timeout_flag
);

  localparam int MSW = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam logic [9:0]     PRE_LAST = 10'd999;
  localparam logic [MSW-1:0] MS_LAST  = (TIMEOUT_MS > 1) ? MSW'(TIMEOUT_MS - 1) : '0;
  localparam logic [MSW-1:0] MS_FULL  = MSW'(TIMEOUT_MS);

  logic           dec_hit;
  logic [1:0]     dec_left, dec_right;
  logic           cmd_hit;
  logic           wd_expire;
  logic [9:0]     pre_cnt;
  logic [MSW-1:0] ms_cnt;
  logic [1:0]     tgt_left, tgt_right;

  // Command byte decode; unknown bytes are still accepted but ignored.
  always_comb begin
    dec_hit   = 1'b1;
    dec_left  = DIR_HALT;
    dec_right = DIR_HALT;
    case (cmd_data)
      CMD_FWD:   begin dec_left = DIR_FWD; dec_right = DIR_FWD; end
      CMD_BWD:   begin dec_left = DIR_BWD; dec_right = DIR_BWD; end
      CMD_LEFT:  begin dec_left = DIR_BWD; dec_right = DIR_FWD; end
      CMD_RIGHT: begin dec_left = DIR_FWD; dec_right = DIR_BWD; end
      CMD_STOP:  begin dec_left = DIR_HALT; dec_right = DIR_HALT; end
      default:   dec_hit = 1'b0;
    endcase
  end

  assign cmd_hit = cmd_valid && cmd_ready && dec_hit;

  // Expiry is the edge on which the ms counter would reach TIMEOUT_MS; a
  // valid command on that same edge wins and restarts the watchdog instead.
  assign wd_expire = !cmd_hit && (ms_cnt != MS_FULL) &&
                     (pre_cnt == PRE_LAST) && (ms_cnt == MS_LAST);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) cmd_ready <= 1'b0;
    else        cmd_ready <= 1'b1;
  end

  // Watchdog: microsecond prescaler feeding a millisecond counter. Once the
  // ms counter reaches TIMEOUT_MS both counters freeze until the next valid
  // command, so nothing wraps.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (cmd_hit) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (ms_cnt != MS_FULL) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        ms_cnt  <= ms_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Target registers and timeout flag. The latest valid command always
  // overwrites the targets, even while a channel is in its dead time.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      tgt_left     <= DIR_HALT;
      tgt_right    <= DIR_HALT;
      timeout_flag <= 1'b0;
    end else if (cmd_hit) begin
      tgt_left     <= dec_left;
      tgt_right    <= dec_right;
      timeout_flag <= 1'b0;
    end else if (wd_expire) begin
      tgt_left     <= DIR_HALT;
      tgt_right    <= DIR_HALT;
      timeout_flag <= 1'b1;
    end
  end

  motor_dir_seq #(.DEAD_US(DEAD_US)) u_left (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .target   (tgt_left),
    .dir      (dir_left)
  );

  motor_dir_seq #(.DEAD_US(DEAD_US)) u_right (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .target   (tgt_right),
    .dir      (dir_right)
  );

endmodule

// File: doc/motor_cmd_seq.md
MOTOR_CMD_SEQ -- requirements
Module: motor_cmd_seq

Interface
REQ-001 SHALL have parameter DEAD_US, default 20000: reversal dead time in clk_1MHz cycles (us).
REQ-002 SHALL have parameter TIMEOUT_MS, default 500: command watchdog period in ms.
REQ-003 SHALL have port clk_1MHz, input, 1: 1 MHz system clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command byte present.
REQ-006 SHALL have port cmd_data, input, 8: command byte.
REQ-007 SHALL have port cmd_ready, output, 1: byte accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port dir_left, output, 2: left motor driver direction (11 fwd, 00 bwd, 01 halt).
REQ-009 SHALL have port dir_right, output, 2: right motor driver direction, same encoding.
REQ-010 SHALL have port timeout_flag, output, 1: watchdog expired, motors forced to halt.

Function
REQ-011 SHALL drive cmd_ready high in every cycle out of reset; it is a registered output.
REQ-012 SHALL decode accepted bytes into per-channel targets (left, right): 0x46 'F' = (fwd, fwd); 0x42 'B' = (bwd, bwd); 0x4C 'L' = (bwd, fwd); 0x52 'R' = (fwd, bwd); 0x53 'S' = (halt, halt).
REQ-013 SHALL accept and discard any other byte, with no change to targets or the watchdog.
REQ-014 SHALL let the latest valid command overwrite targets, including during dead time.
REQ-015 SHALL run one FSM per channel, states HALT, FWD, BWD, DEAD; outputs are registered and derive from the state (DEAD and HALT output 01).
REQ-016 SHALL transition HALT->FWD/BWD, FWD/BWD->HALT and DEAD->HALT on target change, with the output changing in the cycle after the target register updates.
REQ-017 SHALL route FWD->BWD and BWD->FWD through DEAD; the output is 01 from the next cycle for exactly DEAD_US cycles, then takes the target current at expiry.
REQ-018 SHALL leave DEAD immediately to HALT if the target becomes halt during DEAD; a target flip back to the pre-DEAD direction does not shorten DEAD.
REQ-019 SHALL hold the state with no output glitch when the target equals the current direction.
REQ-020 SHALL make the watchdog a ms prescaler (0..999) plus ms counter; both restart to zero on every accepted valid command.
REQ-021 SHALL fire the watchdog after exactly TIMEOUT_MS*1000 cycles without a valid command: set timeout_flag and force both targets to halt.
REQ-022 SHALL clear timeout_flag on the next accepted valid command, which is then applied normally.
REQ-023 SHALL give precedence to the command over watchdog expiry when both occur in the same cycle; timeout_flag stays low.
REQ-024 SHALL size the dead-time counter as ceil(log2(DEAD_US+1)) bits and the ms counter as ceil(log2(TIMEOUT_MS+1)) bits; counters saturate and never wrap.
REQ-025 SHALL never emit 10 on dir_left or dir_right.

Reset
REQ-026 SHALL, while rst_n is low, set dir_left = dir_right = 01, both FSMs to HALT, targets to halt, cmd_ready = 0, timeout_flag = 0, and all counters to 0.
REQ-027 SHALL, on reset assertion mid-DEAD or mid-run, force outputs to 01 asynchronously with no wait for the dead time.
REQ-028 SHALL start the watchdog from zero after reset release; with no commands, timeout_flag rises TIMEOUT_MS ms after release.

Structure
REQ-029 SHALL place DIR_FWD/DIR_BWD/DIR_HALT encodings, command byte constants and the channel state enum in shared package motor_pkg.
REQ-030 SHALL implement the per-channel FSM and dead-time counter as sub-module motor_dir_seq, instantiated twice.
REQ-031 SHALL keep command decode, target registers and watchdog in motor_cmd_seq.

Verification
REQ-032 SHALL cover: reset, then 'F' at t0 -> both outputs 11 at t0+2, cmd_ready 1.
REQ-033 SHALL cover: in FWD, send 'B' -> outputs 01 for exactly 20000 cycles, then 00.
REQ-034 SHALL cover: in FWD, send 'B', then 'S' 5000 cycles later -> outputs 01 and stay 01 after 20000 cycles.
REQ-035 SHALL cover: 'L' from HALT -> left 00, right 11 with no dead time; then 'R' -> both pass through 20000-cycle 01 and end left 11, right 00.
REQ-036 SHALL cover: 'F', then no commands for 500000 cycles -> timeout_flag 1 and outputs 01; then 0x41 -> no change; then 'F' -> flag 0, outputs 11.
REQ-037 SHALL cover: valid command in the exact expiry cycle -> timeout_flag stays 0; rst_n low mid-DEAD -> outputs 01 immediately.
